// File: rtl/genblk_rr_arbiter.sv
// Round-robin arbiter sharing one resource among N requesters.
// N is chosen at elaboration by MODE through the named blocks blk1..blk4.
// A grant is held until the owner raises done. Macro ARB_TIMEOUT_EN adds a
// watchdog that forces a release after TIMEOUT busy cycles.
module genblk_rr_arbiter #(
  parameter int unsigned MODE    = 0,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  req,
  input  logic        done,
  output logic [6:0]  gnt,
  output logic [2:0]  gnt_id,
  output logic        busy,
  output logic [31:0] num_req,
  output logic [15:0] grant_cnt,
  output logic        timeout
);

  localparam int unsigned N = (MODE == 1) ? 2 : (MODE == 2) ? 3 : (MODE == 3) ? 5 : 7;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [6:0]  gnt_q, gnt_d;
  logic [2:0]  gnt_id_q, gnt_id_d;
  logic [15:0] cnt_q, cnt_d;
  logic [6:0]  mreq;
  logic [2:0]  owner_inc;
  logic [2:0]  winner;
  logic        found;
  logic        expired;

  // Catch an illegal watchdog limit at elaboration.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("genblk_rr_arbiter: TIMEOUT must be in 1..255");
  end

  // Configuration cascade: each block owns its request array, mask and the
  // compare-and-wrap successor of the current owner.
  if (MODE == 1) begin : blk1
    localparam int unsigned NB = 2;
    logic [NB-1:0] req_arr;
    assign req_arr   = NB'(req & 7'((1 << NB) - 1));
    assign mreq      = 7'(req_arr);
    assign num_req   = 32'($bits(req_arr));
    assign owner_inc = (gnt_id_q == 3'(NB - 1)) ? 3'd0 : gnt_id_q + 3'd1;
  end else if (MODE == 2) begin : blk2
    localparam int unsigned NB = 3;
    logic [NB-1:0] req_arr;
    assign req_arr   = NB'(req & 7'((1 << NB) - 1));
    assign mreq      = 7'(req_arr);
    assign num_req   = 32'($bits(req_arr));
    assign owner_inc = (gnt_id_q == 3'(NB - 1)) ? 3'd0 : gnt_id_q + 3'd1;
  end else if (MODE == 3) begin : blk3
    localparam int unsigned NB = 5;
    logic [NB-1:0] req_arr;
    assign req_arr   = NB'(req & 7'((1 << NB) - 1));
    assign mreq      = 7'(req_arr);
    assign num_req   = 32'($bits(req_arr));
    assign owner_inc = (gnt_id_q == 3'(NB - 1)) ? 3'd0 : gnt_id_q + 3'd1;
  end else begin : blk4
    localparam int unsigned NB = 7;
    logic [NB-1:0] req_arr;
    assign req_arr   = req;
    assign mreq      = req_arr;
    assign num_req   = 32'($bits(req_arr));
    assign owner_inc = (gnt_id_q == 3'(NB - 1)) ? 3'd0 : gnt_id_q + 3'd1;
  end

  // Rotating search: first set request at ptr, ptr+1, ... wrapping at N-1.
  always_comb begin
    logic [3:0] idx;
    found  = 1'b0;
    winner = 3'd0;
    idx    = 4'd0;
    for (int k = 0; k < 7; k++) begin
      if (k < int'(N)) begin
        idx = {1'b0, ptr_q} + 4'(k);
        // ptr < N and k < N, so one subtraction is enough to wrap.
        if (idx >= 4'(N)) idx = idx - 4'(N);
        if (!found && mreq[idx[2:0]]) begin
          found  = 1'b1;
          winner = idx[2:0];
        end
      end
    end
  end

  // Next-state logic: grant from idle, release on done or watchdog expiry.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d  = StBusy;
          gnt_d    = 7'd1 << winner;
          gnt_id_d = winner;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
      end
      StBusy: begin
        if (done || expired) begin
          state_d  = StIdle;
          gnt_d    = 7'd0;
          gnt_id_d = 3'd0;
          ptr_d    = owner_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= 3'd0;
      gnt_q    <= 7'd0;
      gnt_id_q <= 3'd0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q;
  logic       timeout_q;

  assign expired = (state_q == StBusy) && (hold_q == 8'(TIMEOUT));

  // Hold counter: cleared on grant and release, counts every busy cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 8'd0;
    end else if (state_q == StBusy && !(done || expired)) begin
      hold_q <= hold_q + 8'd1;
    end else begin
      hold_q <= 8'd0;
    end
  end

  // One-cycle pulse when the watchdog, not done, ends the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expired && !done;
    end
  end

  assign timeout = timeout_q;
`else
  assign expired = 1'b0;
  assign timeout = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = (state_q == StBusy);
  assign grant_cnt = cnt_q;

endmodule
